dds_pwm_modulator: RTL

- Downstream stage of the DDS core. Consumes the signed 16-bit sine samples produced by the phase-to-amplitude stage.
- Converts each sample to a PWM duty cycle at CNT_W-bit resolution and drives the gate output(s) for the filter/bridge.
- Runs on the fast system clock; samples arrive as single-cycle strobes at the DDS sample rate.
- Compare value is double-buffered and updated only at PWM period boundaries, so outputs are glitch-free.

---
 rtl/dds_pwm_pkg.sv | 18 +
 rtl/dds_pwm_deadtime.sv | 37 +++
 rtl/dds_pwm_modulator.sv | 100 ++++++++++
 3 files changed

// File: rtl/dds_pwm_pkg.sv
// dds_pwm_pkg: shared FSM states, default sizing and sample-to-duty mapping for the DDS PWM stage
package dds_pwm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int SAMPLE_W_DEF = 16;
  localparam int CNT_W_DEF    = 10;
  localparam int CNT_MAX      = 2**CNT_W_DEF - 1;
  localparam int DUTY_MID     = 2**(CNT_W_DEF - 1);

  // Offset-binary conversion (MSB flip) of a sw-bit signed sample, keeping its top cw bits
  function automatic logic [31:0] map_duty(input logic [31:0] s, input int sw, input int cw);
    logic [31:0] u;
    u = s ^ (32'd1 << (sw - 1));
    return u >> (sw - cw);
  endfunction

endpackage

// File: rtl/dds_pwm_deadtime.sv
// dds_pwm_deadtime: blanks both gate outputs for DT_CYCLES clocks after any raw edge
module dds_pwm_deadtime #(
  parameter int DT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_h,
  input  logic raw_l,
  output logic pwm_h,
  output logic pwm_l
);

  localparam int DW = $clog2(DT_CYCLES + 1);

  logic [DW-1:0] dt_cnt;
  logic          prev_h, prev_l, toggle;

  assign toggle = (raw_h != prev_h) || (raw_l != prev_l);

  // Any edge restarts the blanking window, so pulses shorter than it never reach the gate
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_h <= 1'b0;
      prev_l <= 1'b0;
      dt_cnt <= '0;
      pwm_h  <= 1'b0;
      pwm_l  <= 1'b0;
    end else begin
      prev_h <= raw_h;
      prev_l <= raw_l;
      dt_cnt <= toggle ? DW'(DT_CYCLES - 1) : (dt_cnt != '0) ? dt_cnt - 1'b1 : '0;
      pwm_h  <= !toggle && (dt_cnt == '0) && raw_h;
      pwm_l  <= !toggle && (dt_cnt == '0) && raw_l;
    end
  end

endmodule

// File: rtl/dds_pwm_modulator.sv
// dds_pwm_modulator: double-buffered sample-to-PWM converter; DDS_PWM_DEADTIME_EN adds dead-time
module dds_pwm_modulator import dds_pwm_pkg::*; #(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                pwm_h,
  output logic                pwm_l,
  output logic                period_start,
  output logic                sample_overrun,
  output logic                busy
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] DMID = {1'b1, {(CNT_W-1){1'b0}}};

  if (CNT_W > SAMPLE_W || DT_CYCLES < 1 || DT_CYCLES > 2**(CNT_W-2)) begin : g_bad_params
    $error("dds_pwm_modulator: parameter out of range");
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, hold_reg, duty_shadow, duty_in;
  logic             pending, active, load, cmp;

  assign duty_in = CNT_W'(map_duty(32'(sample_in), SAMPLE_W, CNT_W));
  assign active  = state != IDLE;
  assign load    = active && (cnt == CMAX);
  assign cmp     = active && (cnt < duty_shadow);
  assign busy    = active;

  // A stop request only takes effect at the end of the running period
  always_comb begin
    state_n = !active ? (enable ? RUN : IDLE) : enable ? RUN : load ? IDLE : DRAIN;
  end

  // State register and free-running period counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= active ? cnt + 1'b1 : '0;
    end
  end

  // Sample capture into hold_reg; shadow compare value only changes on the period's last cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg       <= '0;
      pending        <= 1'b0;
      duty_shadow    <= DMID;
      sample_overrun <= 1'b0;
    end else if (sample_valid && load) begin
      duty_shadow <= duty_in;
      pending     <= 1'b0;
    end else if (sample_valid) begin
      hold_reg       <= duty_in;
      pending        <= 1'b1;
      sample_overrun <= sample_overrun | pending;
    end else if (load && pending) begin
      duty_shadow <= hold_reg;
      pending     <= 1'b0;
    end
  end

  // Period marker registered so it lines up with the first output cycle of each period
  always_ff @(posedge clk) begin
    if (reset) period_start <= 1'b0;
    else       period_start <= active && (cnt == '0);
  end

`ifdef DDS_PWM_DEADTIME_EN
  dds_pwm_deadtime #(.DT_CYCLES(DT_CYCLES)) u_deadtime (
    .clk   (clk),
    .reset (reset),
    .raw_h (cmp),
    .raw_l (active && !cmp),
    .pwm_h (pwm_h),
    .pwm_l (pwm_l)
  );
`else
  // Complementary gate pair with one clock of compare latency, both low while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      pwm_h <= cmp;
      pwm_l <= active && !cmp;
    end
  end
`endif

endmodule
